// File: rtl/uart_sram_tx_interface.sv
// Streams a block of 16-bit SRAM words out of an 8N1 UART, high byte first, prefetching
// the next word during the low-byte frame. Optional trailing XOR frame: UART_TX_CHECKSUM_EN.
module uart_sram_tx_interface #(
  parameter int unsigned CLKS_PER_BIT      = 434,
  parameter int unsigned SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned LatW  = $clog2(SRAM_READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_START_BIT,
    S_TX_DATA,
    S_TX_STOP_BIT,
    S_TX_DONE
  } tx_state_e;

  tx_state_e        state_q, state_d;
  logic [17:0]      addr_q, addr_d;
  logic [17:0]      remain_q, remain_d;
  logic [7:0]       low_byte_q, low_byte_d;
  logic [15:0]      next_q, next_d;
  logic             next_vld_q, next_vld_d;
  logic             fetch_pend_q, fetch_pend_d;
  logic [LatW-1:0]  lat_q, lat_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             on_low_q, on_low_d;
  logic             last_tick;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             csum_frame_q, csum_frame_d;
`endif

  assign last_tick    = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = (state_q != S_TX_IDLE);
  assign Done         = (state_q == S_TX_DONE);

  always_comb begin
    UART_TX_O = 1'b1;
    if (state_q == S_TX_START_BIT) begin
      UART_TX_O = 1'b0;
    end else if (state_q == S_TX_DATA) begin
      UART_TX_O = shift_q[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    low_byte_d   = low_byte_q;
    next_d       = next_q;
    next_vld_d   = next_vld_q;
    fetch_pend_d = fetch_pend_q;
    lat_d        = lat_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    on_low_d     = on_low_q;
`ifdef UART_TX_CHECKSUM_EN
    csum_d       = csum_q;
    csum_frame_d = csum_frame_q;
`endif

    // Background prefetch: runs inside the low-byte frame, which is far longer than the latency.
    if (fetch_pend_q) begin
      if (lat_q == '0) begin
        next_d       = SRAM_read_data;
        next_vld_d   = 1'b1;
        fetch_pend_d = 1'b0;
        remain_d     = remain_q - 18'd1;
`ifdef UART_TX_CHECKSUM_EN
        csum_d       = csum_q ^ SRAM_read_data[15:8] ^ SRAM_read_data[7:0];
`endif
      end else begin
        lat_d = lat_q - LatW'(1);
      end
    end

    unique case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          addr_d       = Start_address;
          remain_d     = Word_count;
          next_vld_d   = 1'b0;
          fetch_pend_d = 1'b0;
          baud_d       = '0;
          bit_d        = '0;
          on_low_d     = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
          csum_d       = '0;
`endif
          if (Word_count == '0) begin
`ifdef UART_TX_CHECKSUM_EN
            shift_d      = '0;
            csum_frame_d = 1'b1;
            state_d      = S_TX_START_BIT;
`else
            state_d      = S_TX_DONE;
`endif
          end else begin
            state_d = S_TX_READ;
          end
        end
      end

      S_TX_READ: begin
        lat_d   = '0;
        state_d = S_TX_WAIT;
      end

      S_TX_WAIT: begin
        if (lat_q == LatW'(SRAM_READ_LATENCY - 1)) begin
          shift_d    = SRAM_read_data[15:8];
          low_byte_d = SRAM_read_data[7:0];
          remain_d   = remain_q - 18'd1;
`ifdef UART_TX_CHECKSUM_EN
          csum_d     = csum_q ^ SRAM_read_data[15:8] ^ SRAM_read_data[7:0];
`endif
          on_low_d   = 1'b0;
          baud_d     = '0;
          state_d    = S_TX_START_BIT;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end

      S_TX_START_BIT: begin
        if (last_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_TX_DATA;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      S_TX_DATA: begin
        if (last_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_TX_STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      S_TX_STOP_BIT: begin
        if (last_tick) begin
          baud_d  = '0;
          state_d = S_TX_START_BIT;
`ifdef UART_TX_CHECKSUM_EN
          if (csum_frame_q) begin
            csum_frame_d = 1'b0;
            state_d      = S_TX_DONE;
          end else
`endif
          if (!on_low_q) begin
            on_low_d = 1'b1;
            shift_d  = low_byte_q;
            if (remain_q != '0) begin
              addr_d       = addr_q + 18'd1;
              fetch_pend_d = 1'b1;
              lat_d        = LatW'(SRAM_READ_LATENCY);
            end
          end else if (next_vld_q) begin
            on_low_d   = 1'b0;
            next_vld_d = 1'b0;
            shift_d    = next_q[15:8];
            low_byte_d = next_q[7:0];
          end else begin
`ifdef UART_TX_CHECKSUM_EN
            shift_d      = csum_q;
            csum_frame_d = 1'b1;
`else
            state_d      = S_TX_DONE;
`endif
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      S_TX_DONE: state_d = S_TX_IDLE;

      default: state_d = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_TX_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      low_byte_q   <= '0;
      next_q       <= '0;
      next_vld_q   <= 1'b0;
      fetch_pend_q <= 1'b0;
      lat_q        <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      on_low_q     <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      csum_q       <= '0;
      csum_frame_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      low_byte_q   <= low_byte_d;
      next_q       <= next_d;
      next_vld_q   <= next_vld_d;
      fetch_pend_q <= fetch_pend_d;
      lat_q        <= lat_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      on_low_q     <= on_low_d;
`ifdef UART_TX_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_frame_q <= csum_frame_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: per-cycle line/Busy/Done model built from frame rules,
// a line decoder for byte-level literal checks, and randomized dumps.
module tb_uart_sram_tx_interface;

  localparam int C = 4;
  localparam int L = 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  uart_sram_tx_interface #(
    .CLKS_PER_BIT     (C),
    .SRAM_READ_LATENCY(L)
  ) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .Start         (Start),
    .Start_address (Start_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n     (SRAM_we_n),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 Clock = ~Clock;

  // SRAM: data for the address seen in cycle t is valid in cycle t+L
  logic [15:0] mem [262144];
  logic [15:0] pipe [L];
  always @(posedge Clock) begin
    pipe[0] <= mem[SRAM_address];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign SRAM_read_data = pipe[L-1];

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  exp_q[$];        // {tx, busy, done} per cycle from exp_base on
  int unsigned exp_base = 0;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  rx_q[$];
  int          busy_cnt, done_cnt, first_low, done_cyc;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    for (int k = 0; k < C; k++) exp_q.push_back(3'b010);
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < C; k++) exp_q.push_back({b[j], 2'b10});
    for (int k = 0; k < C; k++) exp_q.push_back(3'b110);
    exp_bytes.push_back(b);
  endfunction

  function automatic void model(input logic [17:0] a, input logic [17:0] n);
    logic [7:0]  cks;
    logic [17:0] p;
    logic [15:0] d;
    cks = 8'h00;
    p = a;
    if (n != 0) for (int k = 0; k < 1 + L; k++) exp_q.push_back(3'b110);
    for (int w = 0; w < int'(n); w++) begin
      d = mem[p];
      push_frame(d[15:8]);
      push_frame(d[7:0]);
      cks = cks ^ d[15:8] ^ d[7:0];
      p = p + 18'd1;
    end
`ifdef UART_TX_CHECKSUM_EN
    push_frame(cks);
`endif
    exp_q.push_back(3'b111);
  endfunction

  // Per-cycle compare plus line decoder
  logic       rx_active = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge Clock) begin
    logic [2:0] e;
    if (!Resetn) begin
      rx_active = 1'b0;
    end else begin
      if (exp_q.size() > 0 && cyc >= exp_base) e = exp_q.pop_front();
      else e = 3'b100;
      checks++;
      if ({SRAM_we_n, UART_TX_O, Busy, Done} !== {1'b1, e}) begin
        errors++;
        $display("FAIL cycle %0d we_n/tx/busy/done got %b%b%b%b want 1%b",
                 cyc, SRAM_we_n, UART_TX_O, Busy, Done, e);
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        done_cyc = int'(cyc);
      end
      if (!UART_TX_O && first_low < 0) first_low = int'(cyc);
      if (!rx_active) begin
        if (!UART_TX_O) begin
          rx_active = 1'b1;
          rx_ph = 0;
        end
      end else begin
        rx_ph++;
        for (int j = 0; j < 8; j++) if (rx_ph == C * (1 + j) + C / 2) rx_byte[j] = UART_TX_O;
        if (rx_ph == 9 * C + C / 2) begin
          checks++;
          if (UART_TX_O !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit cycle %0d got %b want 1", cyc, UART_TX_O);
          end
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic clear_stats();
    exp_bytes.delete();
    rx_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    first_low = -1;
    done_cyc = -1;
  endtask

  task automatic dump(input logic [17:0] a, input logic [17:0] n, input int extra_at,
                      input bit at_done);
    int bound;
    bound = (int'(n) + 2) * 25 * C + 50;
    clear_stats();
    @(posedge Clock); #1;
    Start = 1'b1;
    Start_address = a;
    Word_count = n;
    exp_base = cyc + 1;
    model(a, n);
    @(posedge Clock); #1;
    Start = 1'b0;
    Start_address = 18'($urandom);
    Word_count = 18'($urandom);
    if (extra_at > 0) begin
      repeat (extra_at) @(posedge Clock);
      #1;
      Start = 1'b1;
      Start_address = a + 18'd5;
      Word_count = 18'd7;
      @(posedge Clock); #1;
      Start = 1'b0;
    end
    if (at_done) begin
      for (int i = 0; i < bound && exp_q.size() != 1; i++) begin
        @(posedge Clock); #1;
      end
      Start = 1'b1;
      Start_address = a;
      Word_count = 18'd1;
      @(posedge Clock); #1;
      Start = 1'b0;
    end
    for (int i = 0; i < bound && exp_q.size() > 0; i++) @(posedge Clock);
    #1;
    chk("dump_timeout_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(posedge Clock);
    #1;
    chk("rx_byte_count", rx_q.size(), exp_bytes.size());
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
      chk($sformatf("rx_byte[%0d]", i), int'(rx_q[i]), int'(exp_bytes[i]));
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA55A;
    mem[262143] = 16'hBEEF;
    mem[200] = 16'h1234;

    // Reset values
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_tx", int'(UART_TX_O), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_addr", int'(SRAM_address), 0);
    chk("rst_we_n", int'(SRAM_we_n), 1);
    Resetn = 1'b1;
    repeat (3) @(posedge Clock);

    // One word A55A
    dump(18'd0, 18'd1, 0, 1'b0);
    chk("w1_done_pulses", done_cnt, 1);
`ifdef UART_TX_CHECKSUM_EN
    chk("w1_busy_cycles", busy_cnt, 124);
    chk("w1_serial_span", done_cyc - first_low, 120);
    chk("w1_cks", (rx_q.size() > 2) ? int'(rx_q[2]) : -1, 'hFF);
`else
    chk("w1_busy_cycles", busy_cnt, 84);
    chk("w1_serial_span", done_cyc - first_low, 80);
`endif
    chk("w1_byte0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'hA5);
    chk("w1_byte1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'h5A);

    // Start while busy is ignored
    dump(18'd0, 18'd1, 20, 1'b0);
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_byte0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'hA5);
    chk("busy_start_byte1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'h5A);

    // Start coinciding with Done is ignored
    dump(18'd0, 18'd1, 0, 1'b1);
    chk("start_at_done_pulses", done_cnt, 1);

    // Three words back to back
    dump(18'd100, 18'd3, 0, 1'b0);
`ifdef UART_TX_CHECKSUM_EN
    chk("w3_serial_span", done_cyc - first_low, 280);
`else
    chk("w3_serial_span", done_cyc - first_low, 240);
    chk("w3_frames", rx_q.size(), 6);
`endif

    // Address wrap
    dump(18'd262143, 18'd2, 0, 1'b0);
    chk("wrap_b0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'hBE);
    chk("wrap_b1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'hEF);
    chk("wrap_b2", (rx_q.size() > 2) ? int'(rx_q[2]) : -1, 'hA5);
    chk("wrap_b3", (rx_q.size() > 3) ? int'(rx_q[3]) : -1, 'h5A);

    // Zero words
    dump(18'd5, 18'd0, 0, 1'b0);
    chk("zero_done_pulses", done_cnt, 1);
`ifdef UART_TX_CHECKSUM_EN
    chk("zero_frames", rx_q.size(), 1);
    chk("zero_cks", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 0);
`else
    chk("zero_frames", rx_q.size(), 0);
    chk("zero_busy_cycles", busy_cnt, 1);
`endif

    // Reset during third data bit of the first frame (0x12: bit 2 is 0)
    clear_stats();
    @(posedge Clock); #1;
    Start = 1'b1;
    Start_address = 18'd200;
    Word_count = 18'd1;
    exp_base = cyc + 1;
    model(18'd200, 18'd1);
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int i = 0; i < 200 && cyc < exp_base + 1 + L + 3 * C + 1; i++) @(posedge Clock);
    #1;
    chk("pre_rst_tx", int'(UART_TX_O), 0);
    Resetn = 1'b0;
    #1;
    chk("abort_tx", int'(UART_TX_O), 1);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    exp_q.delete();
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    clear_stats();
    repeat (10) @(posedge Clock);
    chk("abort_no_done", done_cnt, 0);
    dump(18'd200, 18'd1, 0, 1'b0);
    chk("after_abort_b0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'h12);
    chk("after_abort_b1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'h34);

    // Randomized dumps
    for (int t = 0; t < 8; t++) begin
      logic [17:0] a;
      a = (t % 3 == 0) ? 18'(262144 - $urandom_range(1, 3)) : 18'($urandom);
      dump(a, 18'($urandom_range(0, 4)), (t % 2 == 1) ? int'($urandom_range(5, 60)) : 0,
           (t % 4 == 2));
      chk("rand_done_pulses", done_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
